// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache and RAM buses shared by cache_mem_arbiter
interface cache_mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache arbiter for one shared RAM; ARB_STATS_EN adds grant/conflict counters
module cache_mem_arbiter #(
    parameter int BURST    = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]          igrant_cnt,
    output logic [31:0]          dgrant_cnt,
    output logic [31:0]          conflict_cnt
`endif
);
    localparam int BW = $clog2(BURST + 1);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

    state_t         state, next_state;
    logic [BW-1:0]  burst_cnt;
    logic [SW-1:0]  starve_cnt;
    logic           burst_inc;
    logic           access;
    logic           dreq;
    logic           enter_ignt;
    logic           enter_dgnt;

    assign access     = (bus.ramstate == RAM_ACCESS);
    assign dreq       = bus.dREN | bus.dWEN;
    assign enter_ignt = (state != IGNT) && (next_state == IGNT);
    assign enter_dgnt = (state != DGNT) && (next_state == DGNT);

    // Load data is a pass-through; consumers qualify it with their own wait.
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            state <= next_state;
            if (enter_dgnt)
                burst_cnt <= '0;
            else if (burst_inc)
                burst_cnt <= burst_cnt + BW'(1);
            if (enter_ignt)
                starve_cnt <= '0;
            else if (bus.iREN && state != IGNT && starve_cnt != SW'(MAX_WAIT))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_comb begin
        next_state   = state;
        burst_inc    = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        case (state)
            IDLE: begin
                // A starved icache outranks the dcache; otherwise the dcache wins ties.
                if (bus.iREN && starve_cnt == SW'(MAX_WAIT))
                    next_state = IGNT;
                else if (dreq)
                    next_state = DGNT;
                else if (bus.iREN)
                    next_state = IGNT;
            end
            IGNT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    next_state = IDLE;
                end else if (access) begin
                    bus.iwait  = 1'b0;
                    next_state = IDLE;
                end
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (bus.dWEN)
                    bus.ramWEN = 1'b1;
                else if (bus.dREN)
                    bus.ramREN = 1'b1;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (access) begin
                    bus.dwait = 1'b0;
                    burst_inc = 1'b1;
                    if (burst_cnt + BW'(1) == BW'(BURST))
                        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            igrant_cnt   <= '0;
            dgrant_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (enter_ignt)
                igrant_cnt <= igrant_cnt + 32'd1;
            if (enter_dgnt)
                dgrant_cnt <= dgrant_cnt + 32'd1;
            if (state == IDLE && bus.iREN && dreq)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences one shared single-port RAM between the instruction cache and the data cache.
- Grants the RAM to one requester at a time. Holds a data-cache grant across a two-word block transfer.
- Returns per-requester wait/load responses.
- Applies a starvation guard so instruction fetch cannot be locked out by back-to-back data-cache writebacks and fills.

Parameters:
- BURST, 2: number of completed RAM accesses the dcache may perform per grant.
- MAX_WAIT, 8: icache blocked-cycle count at which the icache gets priority at the next arbitration.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; 0 only in the cycle its access completes.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; 0 only in the cycle its access completes.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset (nRST low, asynchronous, any state): state=IDLE, owner cleared, burst count=0, starve count=0.
- Outputs during reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- iload and dload are combinationally equal to ramload at all times. Consumers qualify them with their wait signal.
- States: IDLE, IGNT, DGNT. RAM outputs are driven only in IGNT/DGNT; in IDLE all RAM outputs are 0 and both waits are 1.
- IDLE arbitration, evaluated in priority order:
  - iREN=1 and starve count==MAX_WAIT -> IGNT.
  - Else dREN|dWEN -> DGNT with burst count=0.
  - Else iREN -> IGNT.
  - Else stay in IDLE.
- Latency: a request is sampled in IDLE at cycle 0. RAM enables are asserted from cycle 1. The minimum completion is cycle 1, if ramstate==ACCESS that cycle.
- IGNT:
  - Drive ramREN=1, ramaddr=iaddr.
  - In a cycle with ramstate==ACCESS: iwait=0, next state IDLE.
  - If iREN drops before completion: next state IDLE, no completion pulse.
- DGNT:
  - Drive ramaddr=daddr, ramstore=dstore.
  - If dWEN=1, drive ramWEN=1 and ramREN=0; dWEN has priority when dREN and dWEN are both high.
  - Else if dREN=1, drive ramREN=1.
  - On ramstate==ACCESS: dwait=0 and burst count increments.
  - The grant is released to IDLE when burst count reaches BURST, or when dREN|dWEN is low.
  - The address may change between words without losing the grant.
- ERROR and BUSY are treated as not-complete: wait held at 1, state unchanged, burst count unchanged.
- Starve count:
  - Increments each cycle iREN=1 and state!=IGNT, saturating at MAX_WAIT.
  - Clears on entry to IGNT.
  - Width is clog2(MAX_WAIT+1).
- Only the granted requester ever sees wait=0. The non-owner's wait is 1 every cycle.
- Simultaneous iREN and dREN in IDLE with starve count<MAX_WAIT: the dcache wins.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds outputs igrant_cnt (32), dgrant_cnt (32) and conflict_cnt (32). All reset to 0 and wrap on overflow.
  - igrant_cnt and dgrant_cnt increment on entry to IGNT and DGNT respectively.
  - conflict_cnt increments in each IDLE cycle where iREN and (dREN|dWEN) are both 1.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40, RAM returns ACCESS on its 2nd cycle with ramload=0xDEADBEEF -> ramREN=1 with ramaddr=0x40; iwait=0 for exactly one cycle, iload=0xDEADBEEF; then IDLE.
- Dcache writeback burst: dWEN=1, daddr 0x80 then 0x84, ramstate ACCESS every cycle -> two ramWEN cycles with correct ramstore, dwait pulses twice; a concurrent iREN is not served until both complete.
- Simultaneous request: iREN=1 and dREN=1 from reset, starve count=0 -> DGNT first; IGNT only after the burst ends.
- Starvation: dcache requests continuously, iREN held, MAX_WAIT=8 -> once starve count hits 8, the next IDLE grants IGNT even though dREN=1.
- ERROR/BUSY stall: ramstate=ERROR for 5 cycles, then ACCESS -> wait stays 1 for 5 cycles, a single completion follows, burst count increments only once.
- Reset mid-burst: assert nRST low during DGNT after word 1 -> all RAM outputs 0 and both waits 1 immediately; after release, a fresh request starts from burst count 0. With ARB_STATS_EN defined, all counters also read 0.
